cnt_cmp_sng_array: RTL and testbench

- Stochastic number generator array that sits directly downstream of the shared-counter array.
- Converts CWID-bit binary operands into unary/stochastic bitstreams. Each lane compares its buffered operand against its lane of the shared count sequence.
- Double-buffers operands so a new operand set can load while the current window streams.
- Frames each bitstream to exactly one counter period (2^CWID cycles) and reports window completion to the downstream uBrain datapath.

---
 rtl/cnt_sng_pkg.sv | 20 ++
 rtl/sng_cmp_lane.sv | 34 +++
 rtl/cnt_cmp_sng_array.sv | 106 ++++++++++
 tb/tb_cnt_cmp_sng_array.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_sng_pkg.sv
// Shared types and constants for the stochastic number generator array.
package cnt_sng_pkg;

   localparam int unsigned DEF_CWID = 8;
   localparam int unsigned WIN_LEN  = 2**DEF_CWID;

   typedef logic [DEF_CWID-1:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } sng_state_t;

   // Window length for an arbitrary count width.
   function automatic int unsigned win_len(input int unsigned cwid);
      return 32'(1) << cwid;
   endfunction

endpackage

// File: rtl/sng_cmp_lane.sv
// One lane: double-buffered operand plus registered unsigned comparator.
module sng_cmp_lane
   import cnt_sng_pkg::*;
#(
   parameter int unsigned CWID = DEF_CWID
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            xfer,
   input  logic            en,
   input  logic [CWID-1:0] src,
   input  logic [CWID-1:0] cnt,
   output logic            sbit
);

   logic [CWID-1:0] shadow;
   logic [CWID-1:0] active;

   // Comparison reads the pre-transfer active value, so a transfer on the
   // final bit of a window only affects the next window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         active <= '0;
         sbit   <= 1'b0;
      end else begin
         if (load) shadow <= src;
         if (xfer) active <= shadow;
         sbit <= en && (active > cnt);
      end
   end

endmodule

// File: rtl/cnt_cmp_sng_array.sv
// Stochastic number generator array: frames per-lane comparator bitstreams
// to one counter period and double-buffers the operand sets.
module cnt_cmp_sng_array
   import cnt_sng_pkg::*;
#(
   parameter int unsigned CWID  = DEF_CWID,
   parameter int unsigned LANES = 512
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             srcValid,
   output logic             srcReady,
   input  logic [CWID-1:0]  srcData [LANES],
   input  logic [CWID-1:0]  cntSeq  [LANES],
   output logic [LANES-1:0] bitSeq,
   output logic             bitValid,
   output logic             winLast,
   output logic             busy
);

   localparam logic [CWID-1:0] TERM = CWID'(win_len(CWID) - 1);

   sng_state_t      state;
   sng_state_t      state_nxt;
   logic [CWID-1:0] win_cnt;
   logic [CWID-1:0] win_cnt_nxt;
   logic            shadow_full;
   logic            shadow_full_nxt;
   logic            load;
   logic            xfer;
   logic            cmp_en;
   logic            last_c;

   assign load = srcValid && srcReady;

   // State, window counter, handshake and output-stage flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         win_cnt     <= '0;
         shadow_full <= 1'b0;
         srcReady    <= 1'b1;
         bitValid    <= 1'b0;
         winLast     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         win_cnt     <= win_cnt_nxt;
         shadow_full <= shadow_full_nxt;
         srcReady    <= ~shadow_full_nxt;
         bitValid    <= cmp_en;
         winLast     <= last_c;
         busy        <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt   = state;
      win_cnt_nxt = win_cnt;
      xfer        = 1'b0;
      cmp_en      = 1'b0;
      last_c      = 1'b0;
      unique case (state)
         IDLE: begin
            if (shadow_full) begin
               xfer      = 1'b1;
               state_nxt = ARMED;
            end
         end
         ARMED: begin
            // Lane 0 stands in for every lane; all counts share one delay.
            if (cntSeq[0] == '0) begin
               cmp_en      = 1'b1;
               win_cnt_nxt = CWID'(1);
               state_nxt   = RUN;
            end
         end
         RUN: begin
            cmp_en      = 1'b1;
            win_cnt_nxt = win_cnt + CWID'(1);
            if (win_cnt == TERM) begin
               last_c      = 1'b1;
               win_cnt_nxt = '0;
               if (shadow_full) xfer = 1'b1;
               else             state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      shadow_full_nxt = load ? 1'b1 : (xfer ? 1'b0 : shadow_full);
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sng_cmp_lane #(.CWID(CWID)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load),
         .xfer  (xfer),
         .en    (cmp_en),
         .src   (srcData[i]),
         .cnt   (cntSeq[i]),
         .sbit  (bitSeq[i])
      );
   end

endmodule

// File: tb/tb_cnt_cmp_sng_array.sv
// Scoreboard bench for cnt_cmp_sng_array with a free-running shared counter.
module tb_cnt_cmp_sng_array;

   localparam int unsigned CW = 8;
   localparam int unsigned NL = 4;

   typedef logic [NL-1:0][CW-1:0] ops_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          src_valid = 1'b0;
   logic          src_ready;
   logic [CW-1:0] src_data [NL];
   logic [CW-1:0] cnt_seq  [NL];
   logic [NL-1:0] bit_seq;
   logic          bit_valid;
   logic          win_last;
   logic          busy;

   int            total = 0;
   int            bad = 0;
   ops_t          sb_q[$];
   ops_t          cur = '0;
   logic [CW-1:0] cnt = '0;
   logic [CW-1:0] cmp_cnt;
   int            idx = 0;
   int            ones [NL];
   int            wins_done = 0;
   bit            contig_req = 1'b0;
   bit            contig_chk = 1'b0;

   cnt_cmp_sng_array #(.CWID(CW), .LANES(NL)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .srcValid (src_valid),
      .srcReady (src_ready),
      .srcData  (src_data),
      .cntSeq   (cnt_seq),
      .bitSeq   (bit_seq),
      .bitValid (bit_valid),
      .winLast  (win_last),
      .busy     (busy)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic ops_t mk(input int a, input int b, input int c, input int d);
      ops_t r;
      r[0] = CW'(a);
      r[1] = CW'(b);
      r[2] = CW'(c);
      r[3] = CW'(d);
      return r;
   endfunction

   // Free-running shared counter, updated just after each rising edge.
   initial begin
      for (int l = 0; l < NL; l++) cnt_seq[l] = '0;
      forever begin
         @(posedge clk);
         #1;
         cnt = cnt + CW'(1);
         for (int l = 0; l < NL; l++) cnt_seq[l] = cnt;
      end
   end

   // Output monitor: pops the expected operand set at each window start.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         idx = 0;
         sb_q.delete();
         contig_chk = 1'b0;
      end else begin
         cmp_cnt = cnt - CW'(1);
         if (contig_chk) begin
            check("b2b_contig", 32'(bit_valid), 32'd1);
            contig_chk = 1'b0;
         end
         if (bit_valid) begin
            if (idx == 0) begin
               if (sb_q.size() == 0) begin
                  check("spurious_window", 32'd1, 32'd0);
                  cur = '0;
               end else begin
                  cur = sb_q.pop_front();
               end
               for (int l = 0; l < NL; l++) ones[l] = 0;
            end
            check("align", 32'(cmp_cnt), 32'(idx));
            for (int l = 0; l < NL; l++) begin
               check("bit", 32'(bit_seq[l]), 32'(idx < int'(cur[l])));
               ones[l] += int'(bit_seq[l]);
            end
            check("win_last", 32'(win_last), 32'(idx == 255));
            if (idx == 255) begin
               for (int l = 0; l < NL; l++) check("ones", 32'(ones[l]), 32'(cur[l]));
               wins_done++;
               idx = 0;
               if (contig_req) begin
                  check("rdy_rise", 32'(src_ready), 32'd1);
                  contig_chk = 1'b1;
                  contig_req = 1'b0;
               end
            end else begin
               idx++;
            end
         end else begin
            check("idle_bits", 32'(bit_seq), 32'd0);
            check("idle_last", 32'(win_last), 32'd0);
            if (idx != 0) begin
               check("gap", 32'(idx), 32'd0);
               idx = 0;
            end
         end
      end
   end

   // Offer a set; while not ready, optionally scramble srcData.
   task automatic send(input ops_t ops, input bit junk);
      int  n = 0;
      bit  done = 1'b0;
      src_valid = 1'b1;
      while (!done) begin
         if (src_ready) begin
            for (int l = 0; l < NL; l++) src_data[l] = ops[l];
            sb_q.push_back(ops);
            @(posedge clk);
            @(negedge clk);
            done = 1'b1;
         end else begin
            if (junk) for (int l = 0; l < NL; l++) src_data[l] = CW'($urandom);
            @(negedge clk);
            n++;
            if (n > 2000) begin
               check("send_timeout", 32'd0, 32'd1);
               done = 1'b1;
            end
         end
      end
      src_valid = 1'b0;
      for (int l = 0; l < NL; l++) src_data[l] = CW'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(sb_q.size() == 0 && idx == 0 && !busy && !bit_valid)) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            check("idle_timeout", 32'd0, 32'd1);
            break;
         end
      end
   endtask

   task automatic wait_cnt(input logic [CW-1:0] v);
      int n = 0;
      while (cnt != v) begin
         @(negedge clk);
         n++;
         if (n > 600) begin
            check("cnt_timeout", 32'd0, 32'd1);
            break;
         end
      end
   endtask

   task automatic wait_idx(input int v);
      int n = 0;
      while (idx != v) begin
         @(negedge clk);
         n++;
         if (n > 1200) begin
            check("idx_timeout", 32'd0, 32'd1);
            break;
         end
      end
   endtask

   initial begin
      for (int l = 0; l < NL; l++) src_data[l] = '0;
      repeat (3) @(negedge clk);
      check("rst_bits",  32'(bit_seq),   32'd0);
      check("rst_valid", 32'(bit_valid), 32'd0);
      check("rst_last",  32'(win_last),  32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_ready", 32'(src_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic window with counter already running.
      send(mk(64, 0, 255, 128), 1'b0);
      wait_idle();

      // Load mid-period: must wait in ARMED for the count to wrap.
      wait_cnt(CW'(37));
      send(mk(3, 1, 254, 200), 1'b0);
      repeat (5) @(negedge clk);
      check("armed_busy",  32'(busy),      32'd1);
      check("armed_quiet", 32'(bit_valid), 32'd0);
      wait_idle();

      // Back-to-back windows, then a third set under backpressure.
      send(mk(10, 20, 30, 40), 1'b0);
      contig_req = 1'b1;
      send(mk(250, 5, 128, 77), 1'b0);
      check("rdy_drop", 32'(src_ready), 32'd0);
      send(mk(3, 255, 0, 1), 1'b1);
      check("rdy_drop2", 32'(src_ready), 32'd0);
      wait_idle();

      // Reset mid-window with a full shadow buffer.
      send(mk(100, 50, 200, 3), 1'b0);
      send(mk(7, 8, 9, 10), 1'b0);
      wait_idx(100);
      rst_n = 1'b0;
      #1;
      check("mid_rst_bits",  32'(bit_seq),   32'd0);
      check("mid_rst_valid", 32'(bit_valid), 32'd0);
      check("mid_rst_last",  32'(win_last),  32'd0);
      check("mid_rst_busy",  32'(busy),      32'd0);
      check("mid_rst_ready", 32'(src_ready), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);

      // Fresh load after reset recovery.
      send(mk(2, 128, 1, 255), 1'b0);
      wait_idle();
      check("windows", 32'(wins_done), 32'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
